ym_timer_regs: RTL and testbench

Z80-side register front end for the YM2610 timer subsystem. Decodes Z80 port writes, address then data, into timer A/B load values, the timer control word and run start/stop strobes consumed by `ym_timers`. Returns the status byte (busy, flag B, flag A) on Z80 reads. All other register writes are forwarded on a generic register-write strobe for the FM/SSG/ADPCM blocks.

---
 rtl/ym_pkg.sv | 20 ++
 rtl/ym_busy.sv | 35 +++
 rtl/ym_timer_regs.sv | 138 +++++++++++++
 tb/tb_ym_timer_regs.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ym_pkg.sv
// Shared register addresses and bit positions for the YM2610 timer front end.
package ym_pkg;

    localparam logic [8:0] YM_REG_TA_HI = 9'h024;
    localparam logic [8:0] YM_REG_TA_LO = 9'h025;
    localparam logic [8:0] YM_REG_TB    = 9'h026;
    localparam logic [8:0] YM_REG_TCTRL = 9'h027;

    localparam int CFG_LOAD_A  = 0;
    localparam int CFG_LOAD_B  = 1;
    localparam int CFG_IRQEN_A = 2;
    localparam int CFG_IRQEN_B = 3;
    localparam int CFG_CLR_A   = 4;
    localparam int CFG_CLR_B   = 5;

    localparam int ST_BUSY   = 7;
    localparam int ST_FLAG_B = 1;
    localparam int ST_FLAG_A = 0;

endpackage

// File: rtl/ym_busy.sv
// Write-busy down-counter: reloads on each accepted data write.
module ym_busy
    import ym_pkg::*;
#(
    parameter int BUSY_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    logic [6:0] count_q;
    logic [6:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = 7'(BUSY_CYCLES);
        end else if (count_q != 7'd0) begin
            count_d = count_q - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 7'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy = (count_q != 7'd0);

endmodule

// File: rtl/ym_timer_regs.sv
// Z80 port decoder for YM2610 timer registers, status readback and
// forwarding of all other register writes.
module ym_timer_regs
    import ym_pkg::*;
#(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       nCS,
    input  logic       nWR,
    input  logic       nRD,
    input  logic [1:0] A,
    input  logic [7:0] D_IN,
    input  logic       FLAG_A,
    input  logic       FLAG_B,
    output logic [7:0] D_OUT,
    output logic [9:0] YMTIMER_TA_LOAD,
    output logic [7:0] YMTIMER_TB_LOAD,
    output logic [5:0] YMTIMER_CONFIG,
    output logic       set_run_A,
    output logic       clr_run_A,
    output logic       set_run_B,
    output logic       clr_run_B,
    output logic       REG_WE,
    output logic [8:0] REG_ADDR,
    output logic [7:0] REG_DATA,
    output logic       BUSY
);

    logic       ws;
    logic       ws_q;
    logic       accept;
    logic       data_wr;
    logic [8:0] addr_q, addr_d;
    logic [9:0] ta_q, ta_d;
    logic [7:0] tb_q, tb_d;
    logic [5:0] cfg_q, cfg_d;
    logic [3:0] run_q, run_d;
    logic       we_q, we_d;
    logic [8:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       busy;

    assign ws      = ~nCS & ~nWR;
    assign accept  = ws & ~ws_q;
    assign data_wr = accept & A[0] & ~busy;

    always_comb begin
        addr_d  = addr_q;
        ta_d    = ta_q;
        tb_d    = tb_q;
        cfg_d   = {2'b00, cfg_q[3:0]};
        run_d   = 4'b0000;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (accept && !A[0]) begin
            addr_d = {A[1], D_IN};
        end
        if (data_wr) begin
            case (addr_q)
                YM_REG_TA_HI: ta_d[9:2] = D_IN;
                YM_REG_TA_LO: ta_d[1:0] = D_IN[1:0];
                YM_REG_TB:    tb_d = D_IN;
                YM_REG_TCTRL: begin
                    cfg_d = D_IN[5:0];
                    // run order: {clr_B, set_B, clr_A, set_A}
                    run_d[0] = D_IN[CFG_LOAD_A] & ~cfg_q[CFG_LOAD_A];
                    run_d[1] = ~D_IN[CFG_LOAD_A] & cfg_q[CFG_LOAD_A];
                    run_d[2] = D_IN[CFG_LOAD_B] & ~cfg_q[CFG_LOAD_B];
                    run_d[3] = ~D_IN[CFG_LOAD_B] & cfg_q[CFG_LOAD_B];
                end
                default: begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = D_IN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ws_q    <= 1'b0;
            addr_q  <= 9'd0;
            ta_q    <= 10'd0;
            tb_q    <= 8'd0;
            cfg_q   <= 6'd0;
            run_q   <= 4'd0;
            we_q    <= 1'b0;
            waddr_q <= 9'd0;
            wdata_q <= 8'd0;
        end else begin
            ws_q    <= ws;
            addr_q  <= addr_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            cfg_q   <= cfg_d;
            run_q   <= run_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    ym_busy #(
        .BUSY_CYCLES(BUSY_CYCLES)
    ) u_busy (
        .clk (CLK),
        .rst (RESET),
        .load(data_wr),
        .busy(busy)
    );

    always_comb begin
        D_OUT            = 8'h00;
        D_OUT[ST_BUSY]   = busy;
        D_OUT[ST_FLAG_B] = FLAG_B;
        D_OUT[ST_FLAG_A] = FLAG_A;
    end

    assign YMTIMER_TA_LOAD = ta_q;
    assign YMTIMER_TB_LOAD = tb_q;
    assign YMTIMER_CONFIG  = cfg_q;
    assign set_run_A       = run_q[0];
    assign clr_run_A       = run_q[1];
    assign set_run_B       = run_q[2];
    assign clr_run_B       = run_q[3];
    assign REG_WE          = we_q;
    assign REG_ADDR        = waddr_q;
    assign REG_DATA        = wdata_q;
    assign BUSY            = busy;

    logic unused_rd;
    assign unused_rd = nRD;

endmodule

// File: tb/tb_ym_timer_regs.sv
// Directed bench for ym_timer_regs with hand-computed expectations.
module tb_ym_timer_regs;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       nCS = 1'b1;
    logic       nWR = 1'b1;
    logic       nRD = 1'b1;
    logic [1:0] A = 2'b00;
    logic [7:0] D_IN = 8'h00;
    logic       FLAG_A = 1'b0;
    logic       FLAG_B = 1'b0;
    logic [7:0] D_OUT;
    logic [9:0] YMTIMER_TA_LOAD;
    logic [7:0] YMTIMER_TB_LOAD;
    logic [5:0] YMTIMER_CONFIG;
    logic       set_run_A, clr_run_A, set_run_B, clr_run_B;
    logic       REG_WE;
    logic [8:0] REG_ADDR;
    logic [7:0] REG_DATA;
    logic       BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    int busy_n, seta_n, clra_n, setb_n, clrb_n, we_n, clr_hi_n;
    logic [8:0] cap_addr;
    logic [7:0] cap_data;

    ym_timer_regs #(.BUSY_CYCLES(32)) dut (
        .CLK(CLK), .RESET(RESET), .nCS(nCS), .nWR(nWR), .nRD(nRD),
        .A(A), .D_IN(D_IN), .FLAG_A(FLAG_A), .FLAG_B(FLAG_B),
        .D_OUT(D_OUT), .YMTIMER_TA_LOAD(YMTIMER_TA_LOAD),
        .YMTIMER_TB_LOAD(YMTIMER_TB_LOAD), .YMTIMER_CONFIG(YMTIMER_CONFIG),
        .set_run_A(set_run_A), .clr_run_A(clr_run_A),
        .set_run_B(set_run_B), .clr_run_B(clr_run_B),
        .REG_WE(REG_WE), .REG_ADDR(REG_ADDR), .REG_DATA(REG_DATA),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (BUSY) busy_n++;
        if (set_run_A) seta_n++;
        if (clr_run_A) clra_n++;
        if (set_run_B) setb_n++;
        if (clr_run_B) clrb_n++;
        if (YMTIMER_CONFIG[5:4] == 2'b11) clr_hi_n++;
        if (REG_WE) begin
            we_n++;
            cap_addr = REG_ADDR;
            cap_data = REG_DATA;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        busy_n = 0; seta_n = 0; clra_n = 0; setb_n = 0; clrb_n = 0;
        we_n = 0; clr_hi_n = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        nCS = 1'b0; nWR = 1'b0; A = a; D_IN = d;
        @(negedge CLK);
        nCS = 1'b1; nWR = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (BUSY && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (BUSY) check("busy_timeout", 32'(BUSY), 32'd0);
    endtask

    initial begin
        clr_counts();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check("rst_ta", 32'(YMTIMER_TA_LOAD), 32'h0);
        check("rst_tb", 32'(YMTIMER_TB_LOAD), 32'h0);
        check("rst_cfg", 32'(YMTIMER_CONFIG), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_dout", 32'(D_OUT), 32'h00);
        check("rst_we", 32'(REG_WE), 32'h0);

        wr(2'b00, 8'h24);
        check("addr_no_busy", 32'(BUSY), 32'h0);
        wr(2'b01, 8'hA5);
        wait_idle();
        check("ta_hi", 32'(YMTIMER_TA_LOAD), 32'h294);
        check("busy_len1", 32'(busy_n), 32'd32);
        clr_counts();
        wr(2'b00, 8'h25);
        wr(2'b01, 8'h03);
        wait_idle();
        check("ta_full", 32'(YMTIMER_TA_LOAD), 32'h297);
        check("busy_len2", 32'(busy_n), 32'd32);

        clr_counts();
        wr(2'b00, 8'h27);
        wr(2'b01, 8'h05);
        wait_idle();
        check("cfg05", 32'(YMTIMER_CONFIG), 32'h05);
        check("seta_cnt", 32'(seta_n), 32'd1);
        check("clra_none", 32'(clra_n), 32'd0);
        check("runb_none", 32'(setb_n + clrb_n), 32'd0);
        clr_counts();
        wr(2'b01, 8'h04);
        wait_idle();
        check("cfg04", 32'(YMTIMER_CONFIG), 32'h04);
        check("clra_cnt", 32'(clra_n), 32'd1);
        check("seta_none", 32'(seta_n), 32'd0);
        clr_counts();
        wr(2'b01, 8'h04);
        wait_idle();
        check("same_nopulse", 32'(seta_n + clra_n + setb_n + clrb_n), 32'd0);
        clr_counts();
        wr(2'b01, 8'h06);
        wait_idle();
        check("setb_cnt", 32'(setb_n), 32'd1);
        clr_counts();
        wr(2'b01, 8'h30);
        wait_idle();
        check("clr_pulse", 32'(clr_hi_n), 32'd1);
        check("cfg_after30", 32'(YMTIMER_CONFIG), 32'h00);
        check("clrb_cnt", 32'(clrb_n), 32'd1);

        clr_counts();
        wr(2'b00, 8'h26);
        wr(2'b01, 8'h40);
        wr(2'b01, 8'h80);
        wait_idle();
        check("tb_drop", 32'(YMTIMER_TB_LOAD), 32'h40);
        check("busy_norestart", 32'(busy_n), 32'd32);

        clr_counts();
        wr(2'b10, 8'h10);
        wr(2'b11, 8'h7F);
        wait_idle();
        check("we_cnt", 32'(we_n), 32'd1);
        check("we_addr", 32'(cap_addr), 32'h110);
        check("we_data", 32'(cap_data), 32'h7F);
        check("ta_kept", 32'(YMTIMER_TA_LOAD), 32'h297);
        check("tb_kept", 32'(YMTIMER_TB_LOAD), 32'h40);

        FLAG_A = 1'b1; FLAG_B = 1'b0;
        clr_counts();
        wr(2'b00, 8'h30);
        @(negedge CLK);
        nCS = 1'b0; nWR = 1'b0; A = 2'b01; D_IN = 8'h55;
        repeat (2) @(negedge CLK);
        check("dout_busy", 32'(D_OUT), 32'h81);
        repeat (38) @(negedge CLK);
        nCS = 1'b1; nWR = 1'b1;
        wait_idle();
        check("held_once", 32'(we_n), 32'd1);
        check("dout_idle", 32'(D_OUT), 32'h01);

        clr_counts();
        wr(2'b01, 8'h11);
        wait_idle();
        nCS = 1'b0; nWR = 1'b0; A = 2'b01; D_IN = 8'h22;
        @(negedge CLK);
        nCS = 1'b1; nWR = 1'b1;
        wait_idle();
        check("b2b_cnt", 32'(we_n), 32'd2);
        check("b2b_data", 32'(cap_data), 32'h22);

        clr_counts();
        @(negedge CLK);
        RESET = 1'b1; nCS = 1'b0; nWR = 1'b0; A = 2'b01; D_IN = 8'h99;
        @(negedge CLK);
        RESET = 1'b0; nCS = 1'b1; nWR = 1'b1;
        check("rst_prio_we", 32'(we_n), 32'd0);
        check("rst_prio_busy", 32'(BUSY), 32'h0);

        wr(2'b00, 8'h24);
        wr(2'b01, 8'h12);
        repeat (5) @(negedge CLK);
        check("mid_busy", 32'(BUSY), 32'h1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("rst_mid_busy", 32'(BUSY), 32'h0);
        check("rst_mid_ta", 32'(YMTIMER_TA_LOAD), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
